atm_bank_responder: RTL and testbench

//  Host-side responder for the ATM controller's account requests: verifies PINs and serves

---
 rtl/atm_bank_pkg.sv | 35 +++
 rtl/atm_bank_responder_if.sv | 29 ++
 rtl/atm_account_store.sv | 52 +++++
 rtl/atm_bank_responder.sv | 202 ++++++++++++++++++++
 tb/tb_atm_bank_responder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/atm_bank_pkg.sv
// Shared definitions for the ATM bank responder and the ATM front-end FSM:
// op/status codes, responder state encoding and account defaults.
package atm_bank_pkg;

  localparam int                DATA_W           = 32;
  localparam int                PIN_W            = 4;
  localparam int                DEF_NUM_ACCOUNTS = 4;
  localparam int                DEF_ACCT_W       = 2;
  localparam int                DEF_MAX_TRIES    = 3;
  localparam logic [DATA_W-1:0] DEF_INIT_BALANCE = 32'h000F4240;
  localparam logic [PIN_W-1:0]  DEF_PIN          = 4'b1010;

  typedef enum logic [1:0] {
    OP_VERIFY   = 2'b00,
    OP_BALANCE  = 2'b01,
    OP_DEPOSIT  = 2'b10,
    OP_WITHDRAW = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_BAD_PIN  = 2'b01,
    ST_NO_FUNDS = 2'b10,
    ST_LOCKED   = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_CHECK   = 3'd2,
    S_COMMIT  = 3'd3,
    S_RESPOND = 3'd4
  } state_e;

endpackage

// File: rtl/atm_bank_responder_if.sv
// Request/response channel between the ATM front-end (master) and the
// bank responder (slave); both directions use valid/ready handshakes.
interface atm_bank_responder_if #(
  parameter int ACCT_W = atm_bank_pkg::DEF_ACCT_W
) ();
  import atm_bank_pkg::*;

  logic                req_valid;
  logic                req_ready;
  op_e                 req_op;
  logic [ACCT_W-1:0]   req_account;
  logic [PIN_W-1:0]    req_pin;
  logic [DATA_W-1:0]   req_amount;
  logic                rsp_valid;
  logic                rsp_ready;
  status_e             rsp_status;
  logic [DATA_W-1:0]   rsp_balance;

  modport master (
    output req_valid, req_op, req_account, req_pin, req_amount, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_balance
  );

  modport slave (
    input  req_valid, req_op, req_account, req_pin, req_amount, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_balance
  );

endinterface

// File: rtl/atm_account_store.sv
// Per-account register file {balance, pin, fail count, lock}; one combinational
// read port and one write port, every entry returns to its defaults on reset.
module atm_account_store
  import atm_bank_pkg::*;
#(
  parameter int                NUM_ACCOUNTS = DEF_NUM_ACCOUNTS,
  parameter int                ACCT_W       = DEF_ACCT_W,
  parameter int                FAIL_W       = 2,
  parameter logic [DATA_W-1:0] INIT_BALANCE = DEF_INIT_BALANCE,
  parameter logic [PIN_W-1:0]  DEFAULT_PIN  = DEF_PIN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ACCT_W-1:0]   i_rd_idx,
  output logic [DATA_W-1:0]   o_rd_balance,
  output logic [PIN_W-1:0]    o_rd_pin,
  output logic [FAIL_W-1:0]   o_rd_fail,
  output logic                o_rd_locked,
  input  logic                i_wr_en,
  input  logic [ACCT_W-1:0]   i_wr_idx,
  input  logic [DATA_W-1:0]   i_wr_balance,
  input  logic [FAIL_W-1:0]   i_wr_fail,
  input  logic                i_wr_locked
);

  logic [DATA_W-1:0] r_balance [NUM_ACCOUNTS];
  logic [PIN_W-1:0]  r_pin     [NUM_ACCOUNTS];
  logic [FAIL_W-1:0] r_fail    [NUM_ACCOUNTS];
  logic              r_locked  [NUM_ACCOUNTS];

  // PINs have no change operation, so they only ever hold their reset value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        r_balance[i] <= INIT_BALANCE;
        r_pin[i]     <= DEFAULT_PIN;
        r_fail[i]    <= '0;
        r_locked[i]  <= 1'b0;
      end
    end else if (i_wr_en) begin
      r_balance[i_wr_idx] <= i_wr_balance;
      r_fail[i_wr_idx]    <= i_wr_fail;
      r_locked[i_wr_idx]  <= i_wr_locked;
    end
  end

  assign o_rd_balance = r_balance[i_rd_idx];
  assign o_rd_pin     = r_pin[i_rd_idx];
  assign o_rd_fail    = r_fail[i_rd_idx];
  assign o_rd_locked  = r_locked[i_rd_idx];

endmodule

// File: rtl/atm_bank_responder.sv
// Bank-side responder: captures one account request, checks index/lock/PIN/funds,
// commits a single account write and holds the response until it is taken.
module atm_bank_responder
  import atm_bank_pkg::*;
#(
  parameter int                NUM_ACCOUNTS = DEF_NUM_ACCOUNTS,
  parameter int                ACCT_W       = DEF_ACCT_W,
  parameter logic [DATA_W-1:0] INIT_BALANCE = DEF_INIT_BALANCE,
  parameter logic [PIN_W-1:0]  DEFAULT_PIN  = DEF_PIN,
  parameter int                MAX_TRIES    = DEF_MAX_TRIES
) (
  input  logic                clk,
  input  logic                reset,
  atm_bank_responder_if.slave bus
);

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  state_e              r_state, w_state_nxt;
  logic                w_req_ready, w_take, w_store_we, w_idx_ok;

  op_e                 r_op_p0;
  logic [ACCT_W-1:0]   r_acct_p0;
  logic [PIN_W-1:0]    r_pin_p0;
  logic [DATA_W-1:0]   r_amt_p0;

  logic [DATA_W-1:0]   w_rd_balance;
  logic [PIN_W-1:0]    w_rd_pin;
  logic [FAIL_W-1:0]   w_rd_fail;
  logic                w_rd_locked;

  logic [DATA_W-1:0]   r_bal_p1;
  logic [PIN_W-1:0]    r_spin_p1;
  logic [FAIL_W-1:0]   r_fail_p1;
  logic                r_lock_p1;

  logic [DATA_W:0]     w_sum;
  status_e             w_status;
  logic [DATA_W-1:0]   w_newbal, w_rspbal;
  logic [FAIL_W-1:0]   w_newfail;
  logic                w_newlock, w_we;

  status_e             r_status_p2;
  logic [DATA_W-1:0]   r_newbal_p2, r_rspbal_p2;
  logic [FAIL_W-1:0]   r_newfail_p2;
  logic                r_newlock_p2, r_we_p2;

  logic                r_rsp_valid;
  status_e             r_rsp_status;
  logic [DATA_W-1:0]   r_rsp_balance;

  function automatic logic [FAIL_W-1:0] fail_inc(input logic [FAIL_W-1:0] f);
    if (f >= FAIL_W'(MAX_TRIES)) return f;
    return f + FAIL_W'(1);
  endfunction

  generate
    if (NUM_ACCOUNTS >= (1 << ACCT_W)) begin : g_idx_full
      assign w_idx_ok = 1'b1;
    end else begin : g_idx_part
      assign w_idx_ok = (int'({1'b0, r_acct_p0}) < NUM_ACCOUNTS);
    end
  endgenerate

  atm_account_store #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .ACCT_W       (ACCT_W),
    .FAIL_W       (FAIL_W),
    .INIT_BALANCE (INIT_BALANCE),
    .DEFAULT_PIN  (DEFAULT_PIN)
  ) u_store (
    .clk          (clk),
    .reset        (reset),
    .i_rd_idx     (r_acct_p0),
    .o_rd_balance (w_rd_balance),
    .o_rd_pin     (w_rd_pin),
    .o_rd_fail    (w_rd_fail),
    .o_rd_locked  (w_rd_locked),
    .i_wr_en      (w_store_we),
    .i_wr_idx     (r_acct_p0),
    .i_wr_balance (r_newbal_p2),
    .i_wr_fail    (r_newfail_p2),
    .i_wr_locked  (r_newlock_p2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_take      = 1'b0;
    w_store_we  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_take      = 1'b1;
          w_state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = S_COMMIT;
      S_COMMIT: begin
        w_store_we  = r_we_p2;
        w_state_nxt = S_RESPOND;
      end
      S_RESPOND: if (r_rsp_valid && bus.rsp_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: request capture, then account lookup
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_op_p0   <= bus.req_op;
      r_acct_p0 <= bus.req_account;
      r_pin_p0  <= bus.req_pin;
      r_amt_p0  <= bus.req_amount;
    end
    if (r_state == S_LOOKUP) begin
      r_bal_p1  <= w_rd_balance;
      r_spin_p1 <= w_rd_pin;
      r_fail_p1 <= w_rd_fail;
      r_lock_p1 <= w_rd_locked;
    end
    if (r_state == S_CHECK) begin
      r_status_p2  <= w_status;
      r_newbal_p2  <= w_newbal;
      r_rspbal_p2  <= w_rspbal;
      r_newfail_p2 <= w_newfail;
      r_newlock_p2 <= w_newlock;
    end
  end

  assign w_sum = {1'b0, r_bal_p1} + {1'b0, r_amt_p0};

  // Stage p1 -> p2: checks in priority order; a bad index writes nothing
  always_comb begin
    w_status  = ST_OK;
    w_newbal  = r_bal_p1;
    w_newfail = r_fail_p1;
    w_newlock = r_lock_p1;
    w_we      = 1'b0;
    w_rspbal  = '0;
    if (!w_idx_ok) begin
      w_status = ST_BAD_PIN;
    end else if (r_lock_p1) begin
      w_status = ST_LOCKED;
    end else if (r_pin_p0 != r_spin_p1) begin
      w_we      = 1'b1;
      w_newfail = fail_inc(r_fail_p1);
      if (w_newfail >= FAIL_W'(MAX_TRIES)) begin
        w_newlock = 1'b1;
        w_status  = ST_LOCKED;
      end else begin
        w_status  = ST_BAD_PIN;
      end
    end else begin
      w_we      = 1'b1;
      w_newfail = '0;
      case (r_op_p0)
        OP_WITHDRAW: begin
          if (r_amt_p0 > r_bal_p1) w_status = ST_NO_FUNDS;
          else                     w_newbal = r_bal_p1 - r_amt_p0;
        end
        OP_DEPOSIT: begin
          if (w_sum[DATA_W]) w_status = ST_NO_FUNDS;
          else               w_newbal = w_sum[DATA_W-1:0];
        end
        default: ;
      endcase
      w_rspbal = w_newbal;
    end
  end

  // Stage p2 -> response: commit write, then present the held response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we_p2       <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_status  <= ST_OK;
      r_rsp_balance <= '0;
    end else begin
      if (r_state == S_CHECK) r_we_p2 <= w_we;
      if (r_state == S_COMMIT) begin
        r_rsp_status  <= r_status_p2;
        r_rsp_balance <= r_rspbal_p2;
      end
      if (r_state == S_RESPOND && !r_rsp_valid) r_rsp_valid <= 1'b1;
      else if (r_rsp_valid && bus.rsp_ready)    r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_status  = r_rsp_status;
  assign bus.rsp_balance = r_rsp_balance;

endmodule

// File: tb/tb_atm_bank_responder.sv
// Bench for atm_bank_responder: directed account scenarios followed by random
// transactions, each checked against an account-level reference model.
module tb_atm_bank_responder;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  atm_bank_responder_if bus ();

  atm_bank_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000 ns");
    $fatal(1, "watchdog");
  end

  // Reference model: account-level view of balances, failed tries and locks
  logic [31:0] m_bal  [4];
  int          m_fail [4];
  bit          m_lock [4];
  logic [1:0]  last_st;
  logic [31:0] last_bal;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_bal[i]  = 32'h000F4240;
      m_fail[i] = 0;
      m_lock[i] = 1'b0;
    end
  endtask

  task automatic model(input logic [1:0] op, input int acct, input logic [3:0] pin,
                       input logic [31:0] amt, output logic [1:0] st, output logic [31:0] rb);
    longint sum;
    if (acct < 0 || acct >= 4) begin
      st = 2'b01; rb = 0;
    end else if (m_lock[acct]) begin
      st = 2'b11; rb = 0;
    end else if (pin != 4'b1010) begin
      m_fail[acct] = m_fail[acct] + 1;
      if (m_fail[acct] >= 3) begin
        m_lock[acct] = 1'b1; st = 2'b11;
      end else begin
        st = 2'b01;
      end
      rb = 0;
    end else begin
      m_fail[acct] = 0;
      st = 2'b00;
      if (op == 2'b10) begin
        sum = longint'(m_bal[acct]) + longint'(amt);
        if (sum > 64'h0000_0000_FFFF_FFFF) st = 2'b10;
        else m_bal[acct] = m_bal[acct] + amt;
      end else if (op == 2'b11) begin
        if (amt > m_bal[acct]) st = 2'b10;
        else m_bal[acct] = m_bal[acct] - amt;
      end
      rb = m_bal[acct];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request; checks acceptance, latency and response, then takes it unless held
  task automatic do_req(input logic [1:0] op, input int acct, input logic [3:0] pin,
                        input logic [31:0] amt, input bit hold);
    int n;
    bit got;
    model(op, acct, pin, amt, last_st, last_bal);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid   = 1'b1;
    bus.req_op      = atm_bank_pkg::op_e'(op);
    bus.req_account = acct[1:0];
    bus.req_pin     = pin;
    bus.req_amount  = amt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0; got = 1'b0;
    while (n < 8 && !got) begin
      @(posedge clk); #1;
      n++;
      if (bus.rsp_valid) got = 1'b1;
    end
    chk("rsp_latency", 32'(n), 32'd4);
    chk("rsp_status", 32'(bus.rsp_status), 32'(last_st));
    chk("rsp_balance", bus.rsp_balance, last_bal);
    if (!hold) begin
      @(posedge clk); #1;
      chk("rsp_taken", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = atm_bank_pkg::OP_VERIFY;
    bus.req_account = '0;
    bus.req_pin = '0;
    bus.req_amount = '0;
    bus.rsp_ready = 1'b1;
    model_reset();
    #12;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_status", 32'(bus.rsp_status), 32'd0);
    chk("reset_rsp_balance", bus.rsp_balance, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Balance, deposit, exact withdraw
    do_req(2'b01, 0, 4'hA, 32'd0, 1'b0);
    do_req(2'b10, 1, 4'hA, 32'd500, 1'b0);
    do_req(2'b11, 1, 4'hA, 32'd1000500, 1'b0);
    // Insufficient funds and deposit overflow
    do_req(2'b11, 2, 4'hA, 32'h000F4241, 1'b0);
    do_req(2'b10, 2, 4'hA, 32'hFFFFFFFF, 1'b0);
    do_req(2'b10, 2, 4'hA, 32'd0, 1'b0);
    // Lockout on account 3
    do_req(2'b00, 3, 4'h0, 32'd0, 1'b0);
    do_req(2'b00, 3, 4'h0, 32'd0, 1'b0);
    do_req(2'b00, 3, 4'h0, 32'd0, 1'b0);
    do_req(2'b01, 3, 4'hA, 32'd0, 1'b0);
    // Correct PIN clears the fail count on account 2
    do_req(2'b00, 2, 4'h0, 32'd0, 1'b0);
    do_req(2'b00, 2, 4'hA, 32'd0, 1'b0);
    do_req(2'b00, 2, 4'h5, 32'd0, 1'b0);
    do_req(2'b00, 2, 4'hF, 32'd0, 1'b0);

    // Held response with a competing request that must not be taken
    bus.rsp_ready = 1'b0;
    do_req(2'b01, 0, 4'hA, 32'd0, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_op = atm_bank_pkg::OP_DEPOSIT;
    bus.req_account = 2'd0;
    bus.req_pin = 4'hA;
    bus.req_amount = 32'd7;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rsp_status", 32'(bus.rsp_status), 32'(last_st));
      chk("hold_rsp_balance", bus.rsp_balance, last_bal);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", 32'(bus.rsp_valid), 32'd0);
    do_req(2'b01, 0, 4'hA, 32'd0, 1'b0);

    // Reset while a deposit sits in CHECK
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op = atm_bank_pkg::OP_DEPOSIT;
    bus.req_account = 2'd1;
    bus.req_pin = 4'hA;
    bus.req_amount = 32'd1000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    model_reset();
    @(negedge clk); reset = 1'b0;
    do_req(2'b01, 1, 4'hA, 32'd0, 1'b0);
    do_req(2'b00, 3, 4'hA, 32'd0, 1'b0);

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      logic [1:0]  op;
      int          acct;
      logic [3:0]  pin;
      logic [31:0] amt;
      op   = 2'($urandom_range(0, 3));
      acct = int'($urandom_range(0, 3));
      pin  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hA;
      case ($urandom_range(0, 3))
        0: amt = 32'($urandom_range(0, 2000));
        1: amt = m_bal[acct] + 32'($urandom_range(0, 2)) - 32'd1;
        2: amt = $urandom;
        default: amt = 32'd0;
      endcase
      do_req(op, acct, pin, amt, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
